// File: rtl/vga_pkg.sv
// Shared types and constants for the frame-buffer write path.
package vga_pkg;

  localparam int ADDR_W       = 24;
  localparam int PIX_W        = 16;
  localparam int WR_PAYLOAD_W = ADDR_W + PIX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FLUSH
  } fsm_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef logic [ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/fb_stream_writer_if.sv
// Pixel stream in, SDRAM writer port out; master is the environment, slave the writer.
interface fb_stream_writer_if;
  import vga_pkg::*;

  logic     s_tvalid;
  logic     s_tready;
  rgb565_t  s_tdata;
  logic     s_tuser;
  logic     s_tlast;
  logic     wr_valid;
  logic     wr_ready;
  fb_addr_t wr_addr;
  rgb565_t  wr_data;
  logic [1:0] wr_dqm;

  modport master (
    output s_tvalid, s_tdata, s_tuser, s_tlast, wr_ready,
    input  s_tready, wr_valid, wr_addr, wr_data, wr_dqm
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tuser, s_tlast, wr_ready,
    output s_tready, wr_valid, wr_addr, wr_data, wr_dqm
  );

endinterface

// File: rtl/fb_write_skid.sv
// Single-entry valid/ready output register; accepts a new word in the same cycle the old one leaves.
module fb_write_skid
  import vga_pkg::*;
#(
  parameter int WIDTH = WR_PAYLOAD_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    in_ready_o = !valid_q || out_ready_i;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Data is cleared too so every writer output reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fb_stream_writer.sv
// Writes an RGB565 pixel stream into one of two SDRAM frame buffers, tracking x/y with a linear address counter.
module fb_stream_writer
  import vga_pkg::*;
#(
  parameter int                H_RES      = 800,
  parameter int                V_RES      = 600,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 24'h080000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  input  rgb565_t    s_tdata_i,
  input  logic       s_tuser_i,
  input  logic       s_tlast_i,
  input  logic       ctrl_buf_sel_i,
  output logic       sdram_writer_valid_o,
  input  logic       sdram_writer_ready_i,
  output fb_addr_t   sdram_writer_addr_o,
  output rgb565_t    sdram_writer_data_o,
  output logic [1:0] sdram_writer_dqm_o,
  output logic       frame_done_o,
  output logic       busy_o,
  output logic       err_sof_o,
  output logic       err_eol_o
);

  localparam logic [15:0] X_LAST = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST = 16'(V_RES - 1);
  localparam fb_addr_t    LINE_W = ADDR_W'(H_RES);

  fsm_state_e  state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  fb_addr_t    lin_q, lin_d, line_q, line_d;
  logic        buf_sel_q, buf_sel_d;
  logic        err_sof_q, err_sof_d, err_eol_q, err_eol_d;

  logic        accept, start, eol_pos, line_end, cur_sel;
  logic [15:0] cur_x, cur_y;
  fb_addr_t    cur_lin, cur_line, wr_addr;
  logic        skid_in_valid, skid_in_ready, skid_out_valid;
  logic [WR_PAYLOAD_W-1:0] skid_in_data, skid_out_data;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    lin_d     = lin_q;
    line_d    = line_q;
    buf_sel_d = buf_sel_q;
    err_sof_d = 1'b0;
    err_eol_d = 1'b0;

    s_tready_o = (state_q != FLUSH) && skid_in_ready;
    accept     = s_tvalid_i && s_tready_o;
    start      = accept && s_tuser_i;

    // A start-of-frame beat is pixel 0 wherever the counters currently sit.
    cur_x    = start ? '0 : x_q;
    cur_y    = start ? '0 : y_q;
    cur_lin  = start ? '0 : lin_q;
    cur_line = start ? '0 : line_q;
    cur_sel  = start ? ctrl_buf_sel_i : buf_sel_q;

    eol_pos  = (cur_x == X_LAST);
    line_end = eol_pos || s_tlast_i;
    wr_addr  = (cur_sel ? BUF_STRIDE : '0) + cur_lin;

    skid_in_valid = accept && (start || state_q == WRITE);
    skid_in_data  = {wr_addr, s_tdata_i};
    frame_done_o  = (state_q == FLUSH) && skid_out_valid && sdram_writer_ready_i;

    if (skid_in_valid) begin
      buf_sel_d = cur_sel;
      err_sof_d = start && (state_q == WRITE);
      if (line_end) begin
        // Either marker ends the line; disagreement between them is flagged.
        err_eol_d = (eol_pos != s_tlast_i);
        x_d       = '0;
        y_d       = cur_y + 16'd1;
        line_d    = cur_line + LINE_W;
        lin_d     = cur_line + LINE_W;
        state_d   = (cur_y == Y_LAST) ? FLUSH : WRITE;
      end else begin
        x_d     = cur_x + 16'd1;
        y_d     = cur_y;
        line_d  = cur_line;
        lin_d   = cur_lin + fb_addr_t'(1);
        state_d = WRITE;
      end
    end else if (frame_done_o) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      lin_d   = '0;
      line_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      lin_q     <= '0;
      line_q    <= '0;
      buf_sel_q <= 1'b0;
      err_sof_q <= 1'b0;
      err_eol_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      lin_q     <= lin_d;
      line_q    <= line_d;
      buf_sel_q <= buf_sel_d;
      err_sof_q <= err_sof_d;
      err_eol_q <= err_eol_d;
    end
  end

  fb_write_skid #(.WIDTH(WR_PAYLOAD_W)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_in_ready),
    .in_data_i   (skid_in_data),
    .out_valid_o (skid_out_valid),
    .out_ready_i (sdram_writer_ready_i),
    .out_data_o  (skid_out_data)
  );

  assign sdram_writer_valid_o = skid_out_valid;
  assign sdram_writer_addr_o  = skid_out_data[WR_PAYLOAD_W-1:PIX_W];
  assign sdram_writer_data_o  = rgb565_t'(skid_out_data[PIX_W-1:0]);
  assign sdram_writer_dqm_o   = 2'b00;
  assign busy_o               = (state_q != IDLE);
  assign err_sof_o            = err_sof_q;
  assign err_eol_o            = err_eol_q;

endmodule

// File: tb/tb_fb_stream_writer.sv
// Randomized scenario bench for fb_stream_writer against a pixel-coordinate reference model.
module tb_fb_stream_writer;
  import vga_pkg::*;

  localparam int          H      = 4;
  localparam int          V      = 2;
  localparam logic [23:0] STRIDE = 24'd16;

  typedef struct {
    logic [15:0] data;
    bit          user;
    bit          last;
    bit          sel;
  } beat_t;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctrl_sel;
  logic frame_done, busy, err_sof, err_eol;

  always #5 clk = ~clk;

  fb_stream_writer_if bus ();

  fb_stream_writer #(.H_RES(H), .V_RES(V), .BUF_STRIDE(STRIDE)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .s_tvalid_i           (bus.s_tvalid),
    .s_tready_o           (bus.s_tready),
    .s_tdata_i            (bus.s_tdata),
    .s_tuser_i            (bus.s_tuser),
    .s_tlast_i            (bus.s_tlast),
    .ctrl_buf_sel_i       (ctrl_sel),
    .sdram_writer_valid_o (bus.wr_valid),
    .sdram_writer_ready_i (bus.wr_ready),
    .sdram_writer_addr_o  (bus.wr_addr),
    .sdram_writer_data_o  (bus.wr_data),
    .sdram_writer_dqm_o   (bus.wr_dqm),
    .frame_done_o         (frame_done),
    .busy_o               (busy),
    .err_sof_o            (err_sof),
    .err_eol_o            (err_eol)
  );

  int checks = 0;
  int errors = 0;

  beat_t beats[$];
  word_t exp_q[$];
  word_t obs_q[$];
  int e_sof, e_eol, e_done;
  int n_sof, n_eol, n_done;
  int bp_pct = 0;

  logic        stall_p = 1'b0;
  logic [23:0] stall_addr;
  logic [15:0] stall_data;

  // Backpressure source, changing just after each active edge.
  always @(posedge clk) begin
    #1;
    bus.wr_ready = ($urandom_range(99) >= bp_pct);
  end

  // Monitor: records handshakes, counts pulses, checks that a stalled word holds.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.wr_addr !== stall_addr || bus.wr_data !== stall_data) begin
          errors++;
          $display("FAIL stall_hold got valid %b addr %h data %h required valid 1 addr %h data %h",
                   bus.wr_valid, bus.wr_addr, bus.wr_data, stall_addr, stall_data);
        end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        word_t w;
        w.addr = bus.wr_addr;
        w.data = bus.wr_data;
        obs_q.push_back(w);
      end
      if (err_sof) n_sof++;
      if (err_eol) n_eol++;
      if (frame_done) n_done++;
      stall_p    = bus.wr_valid && !bus.wr_ready;
      stall_addr = bus.wr_addr;
      stall_data = bus.wr_data;
    end
  end

  // Reference: each written pixel lands at base + row*H + col of the frame it belongs to.
  task automatic build_expect();
    bit active = 0;
    int row = 0, col = 0;
    logic [23:0] base = '0;
    word_t w;
    exp_q.delete();
    e_sof = 0; e_eol = 0; e_done = 0;
    foreach (beats[i]) begin
      if (!beats[i].user && !active) continue;
      if (beats[i].user) begin
        if (active) e_sof++;
        active = 1;
        row = 0;
        col = 0;
        base = beats[i].sel ? STRIDE : 24'd0;
      end
      w.addr = base + 24'(row * H + col);
      w.data = beats[i].data;
      exp_q.push_back(w);
      if (col == H - 1 || beats[i].last) begin
        if ((col == H - 1) != beats[i].last) e_eol++;
        if (row == V - 1) begin
          e_done++;
          active = 0;
        end else begin
          row++;
          col = 0;
        end
      end else begin
        col++;
      end
    end
  endtask

  task automatic add_frame(input bit sel, input bit toggle);
    beat_t b;
    for (int i = 0; i < H * V; i++) begin
      b.data = 16'($urandom_range(65535));
      b.user = (i == 0);
      b.last = ((i % H) == H - 1);
      b.sel  = (i == 0 || !toggle) ? sel : 1'($urandom_range(1));
      beats.push_back(b);
    end
  endtask

  task automatic send_beat(input beat_t b, output int waited);
    bit acc;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = rgb565_t'(b.data);
    bus.s_tuser  = b.user;
    bus.s_tlast  = b.last;
    ctrl_sel     = b.sel;
    waited = 0;
    forever begin
      @(negedge clk);
      acc = bus.s_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout waited %0d cycles required acceptance", waited);
        break;
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((obs_q.size() < exp_q.size() || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d words busy %b required %0d words busy 0",
               obs_q.size(), busy, exp_q.size());
    end
  endtask

  task automatic run_stream();
    int w;
    obs_q.delete();
    n_sof = 0; n_eol = 0; n_done = 0;
    build_expect();
    foreach (beats[i]) send_beat(beats[i], w);
    drain();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.wr_valid, bus.wr_addr, bus.wr_data, bus.wr_dqm, frame_done, busy, err_sof, err_eol} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid %b addr %h data %h dqm %b done %b busy %b sof %b eol %b required all 0",
               bus.wr_valid, bus.wr_addr, bus.wr_data, bus.wr_dqm, frame_done, busy, err_sof, err_eol);
    end
    checks++;
    if (bus.s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got %b required 1", bus.s_tready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean();
    beats.delete();
    add_frame(1'b0, 1'b0);
    run_stream();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL clean_count got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL clean_word[%0d] got %h/%h required %h/%h", i,
                 obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (n_done !== 1 || n_eol !== 0 || n_sof !== 0) begin
      errors++;
      $display("FAIL clean_pulses got done %0d eol %0d sof %0d required 1 0 0", n_done, n_eol, n_sof);
    end
    checks++;
    if (busy !== 1'b0 || bus.wr_dqm !== 2'b00) begin
      errors++;
      $display("FAIL clean_idle got busy %b dqm %b required 0 00", busy, bus.wr_dqm);
    end
  endtask

  task automatic test_bufsel();
    beats.delete();
    add_frame(1'b1, 1'b1);
    run_stream();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bufsel_count got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL bufsel_word[%0d] got %h/%h required %h/%h", i,
                 obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (n_done !== e_done || n_eol !== e_eol) begin
      errors++;
      $display("FAIL bufsel_pulses got done %0d eol %0d required %0d %0d", n_done, n_eol, e_done, e_eol);
    end
  endtask

  task automatic test_backpressure();
    beats.delete();
    add_frame(1'b0, 1'b0);
    add_frame(1'b1, 1'b0);
    bp_pct = 30;
    run_stream();
    bp_pct = 0;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL bp_word[%0d] got %h/%h required %h/%h", i,
                 obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (n_done !== 2) begin
      errors++;
      $display("FAIL bp_done got %0d required 2", n_done);
    end
  endtask

  task automatic test_early_eol();
    beat_t b;
    beats.delete();
    for (int i = 0; i < 7; i++) begin
      b.data = 16'($urandom_range(65535));
      b.user = (i == 0);
      b.last = (i == 2 || i == 6);
      b.sel  = 1'b0;
      beats.push_back(b);
    end
    run_stream();
    checks++;
    if (n_eol !== 1 || n_eol !== e_eol) begin
      errors++;
      $display("FAIL eol_pulse got %0d required 1", n_eol);
    end
    checks++;
    if (obs_q.size() < 4 || obs_q[3].addr !== 24'd4) begin
      errors++;
      $display("FAIL eol_realign got %0d words addr3 %h required addr3 000004",
               obs_q.size(), (obs_q.size() >= 4) ? obs_q[3].addr : 24'hxxxxxx);
    end
    checks++;
    if (obs_q.size() !== exp_q.size() || n_done !== 1) begin
      errors++;
      $display("FAIL eol_frame got words %0d done %0d required %0d 1", obs_q.size(), n_done, exp_q.size());
    end
  endtask

  task automatic test_mid_sof();
    beat_t b;
    beats.delete();
    for (int i = 0; i < 12; i++) begin
      b.data = 16'($urandom_range(65535));
      b.user = (i == 0 || i == 4);
      b.last = (i == 3 || i == 7 || i == 11);
      b.sel  = 1'b0;
      beats.push_back(b);
    end
    run_stream();
    checks++;
    if (n_sof !== 1) begin
      errors++;
      $display("FAIL sof_pulse got %0d required 1", n_sof);
    end
    checks++;
    if (obs_q.size() < 5 || obs_q[4].addr !== 24'd0 || obs_q[4].data !== beats[4].data) begin
      errors++;
      $display("FAIL sof_restart got %0d words required word4 at addr 000000", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL sof_word[%0d] got %h/%h required %h/%h", i,
                 obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (n_done !== 1 || n_eol !== 0) begin
      errors++;
      $display("FAIL sof_frame got done %0d eol %0d required 1 0", n_done, n_eol);
    end
  endtask

  task automatic test_idle_and_reset();
    beat_t b;
    int w;
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      b.data = 16'($urandom_range(65535));
      b.user = 1'b0;
      b.last = (i == 3);
      b.sel  = 1'b0;
      send_beat(b, w);
      checks++;
      if (w !== 0) begin
        errors++;
        $display("FAIL idle_tready beat %0d stalled %0d cycles required 0", i, w);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop got words %0d busy %b required 0 0", obs_q.size(), busy);
    end
    beats.delete();
    add_frame(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(beats[i], w);
    checks++;
    if (bus.wr_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pending got valid %b busy %b required 1 1", bus.wr_valid, busy);
    end
    rst_n = 1'b0;
    obs_q.delete();
    #1;
    checks++;
    if ({bus.wr_valid, bus.wr_addr, bus.wr_data, frame_done, busy, err_sof, err_eol} !== '0 || bus.s_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got valid %b addr %h data %h busy %b tready %b required 0 0 0 0 1",
               bus.wr_valid, bus.wr_addr, bus.wr_data, busy, bus.s_tready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_discard got %0d words required 0", obs_q.size());
    end
    beats.delete();
    add_frame(1'b0, 1'b0);
    run_stream();
    checks++;
    if (obs_q.size() !== exp_q.size() || n_done !== 1 || (obs_q.size() > 0 && obs_q[0].addr !== 24'd0)) begin
      errors++;
      $display("FAIL rst_recover got words %0d done %0d required %0d 1", obs_q.size(), n_done, exp_q.size());
    end
  endtask

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.wr_ready = 1'b1;
    ctrl_sel     = 1'b0;
    test_reset();
    test_clean();
    test_bufsel();
    test_backpressure();
    test_early_eol();
    test_mid_sof();
    test_idle_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
